// File: rtl/addsub3_pipe_if.sv
// Operand/result handshake bundle for addsub3_pipe.
// The master side drives operands and out_ready; the slave side returns the result.
interface addsub3_pipe_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] num1;
    logic [DATA_WIDTH-1:0] num2;
    logic [DATA_WIDTH-1:0] num3;
    logic [2:0]            neg;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  overflow;

    modport master (
        output in_valid, num1, num2, num3, neg, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    modport slave (
        input  in_valid, num1, num2, num3, neg, out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/addsub3_pipe.sv
// Two-stage three-operand signed add/subtract with valid/ready flow control,
// exact overflow detection and optional signed saturation.
module addsub3_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int SATURATE   = 0
) (
    input logic           clk,
    input logic           rst,
    addsub3_pipe_if.slave io_bus
);
    // Two guard bits hold the worst case of three negated most-negative operands.
    localparam int EW = DATA_WIDTH + 2;

    function automatic logic [EW-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                               input logic n);
        logic [EW-1:0] e;
        e = {{2{v[DATA_WIDTH-1]}}, v};
        return n ? -e : e;
    endfunction

    logic                  r_s1_valid;
    logic [EW-1:0]         r_s1_p12;
    logic [EW-1:0]         r_s1_t3;
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_overflow;

    logic                  w_s2_load;
    logic                  w_in_ready;
    logic                  w_accept;
    logic [EW-1:0]         w_p12;
    logic [EW-1:0]         w_t3;
    logic [EW-1:0]         w_sum;
    logic [2:0]            w_top;
    logic                  w_ovf;
    logic [DATA_WIDTH-1:0] w_res;

    assign w_s2_load  = !r_s2_valid || io_bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_load;
    assign w_accept   = io_bus.in_valid && w_in_ready;

    assign w_p12 = cond_neg(io_bus.num1, io_bus.neg[0]) + cond_neg(io_bus.num2, io_bus.neg[1]);
    assign w_t3  = cond_neg(io_bus.num3, io_bus.neg[2]);

    // The sum fits the signed range iff the guard bits match the result sign bit.
    assign w_sum = r_s1_p12 + r_s1_t3;
    assign w_top = w_sum[EW-1:DATA_WIDTH-1];
    assign w_ovf = (w_top != 3'b000) && (w_top != 3'b111);

    always_comb begin
        w_res = w_sum[DATA_WIDTH-1:0];
        if ((SATURATE != 0) && w_ovf) begin
            w_res = w_sum[EW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    // NOTE: only control and output state is reset; operand data is qualified by r_s1_valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_p12 <= w_p12;
            r_s1_t3  <= w_t3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= io_bus.in_valid;
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_result   <= w_res;
                    r_overflow <= w_ovf;
                end
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_s2_valid;
    assign io_bus.result    = r_result;
    assign io_bus.overflow  = r_overflow;
endmodule

// File: tb/tb_addsub3_pipe.sv
// Directed bench for addsub3_pipe: a wrapping and a saturating instance
// driven in lockstep with identical stimulus.
module tb_addsub3_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    addsub3_pipe_if #(.DATA_WIDTH(8)) bw ();
    addsub3_pipe_if #(.DATA_WIDTH(8)) bs ();

    addsub3_pipe #(.DATA_WIDTH(8), .SATURATE(0)) dut_wrap (.clk(clk), .rst(rst), .io_bus(bw));
    addsub3_pipe #(.DATA_WIDTH(8), .SATURATE(1)) dut_sat  (.clk(clk), .rst(rst), .io_bus(bs));

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [2:0] n, input logic ordy);
        bw.in_valid = v;  bs.in_valid = v;
        bw.num1 = a;      bs.num1 = a;
        bw.num2 = b;      bs.num2 = b;
        bw.num3 = c;      bs.num3 = c;
        bw.neg = n;       bs.neg = n;
        bw.out_ready = ordy; bs.out_ready = ordy;
    endtask

    // {valid_w, valid_s, result_w, result_s, ovf_w, ovf_s}
    function automatic logic [19:0] obs();
        return {bw.out_valid, bs.out_valid, bw.result, bs.result, bw.overflow, bs.overflow};
    endfunction

    // Integer reference: {wrap_result, sat_result, overflow}
    function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [2:0] n);
        int t1, t2, t3, s;
        logic ovf;
        logic [7:0] wrap, sat;
        t1 = int'($signed(a)); if (n[0]) t1 = -t1;
        t2 = int'($signed(b)); if (n[1]) t2 = -t2;
        t3 = int'($signed(c)); if (n[2]) t3 = -t3;
        s = t1 + t2 + t3;
        ovf  = (s > 127) || (s < -128);
        wrap = s[7:0];
        sat  = ovf ? ((s > 0) ? 8'h7F : 8'h80) : s[7:0];
        return {wrap, sat, ovf};
    endfunction

    task automatic test_reset();
        drive(1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
        rst = 1'b1;
        #3;
        tests_run++;
        if ({obs(), bw.in_ready, bs.in_ready} !== {20'h0, 2'b11}) begin
            tests_failed++;
            $display("FAIL reset_state: got %h, expected %h", {obs(), bw.in_ready, bs.in_ready}, {20'h0, 2'b11});
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({bw.in_ready, bs.in_ready, bw.out_valid, bs.out_valid} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL reset_release: got %b, expected 1100", {bw.in_ready, bs.in_ready, bw.out_valid, bs.out_valid});
        end
    endtask

    task automatic dir_vec(input string name, input logic [2:0] n, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] w, input logic [7:0] s, input logic o);
        drive(1'b1, a, b, c, n, 1'b1);
        #1;
        tests_run++;
        if ({bw.in_ready, bs.in_ready} !== 2'b11) begin
            tests_failed++;
            $display("FAIL %s_in_ready: got %b, expected 11", name, {bw.in_ready, bs.in_ready});
        end
        @(posedge clk); #1;
        drive(1'b0, a, b, c, n, 1'b1);
        tests_run++;
        if ({bw.out_valid, bs.out_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL %s_latency: out_valid %b one cycle after accept, expected 00", name, {bw.out_valid, bs.out_valid});
        end
        @(posedge clk); #1;
        tests_run++;
        if (obs() !== {2'b11, w, s, o, o}) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, obs(), {2'b11, w, s, o, o});
        end
    endtask

    task automatic test_directed();
        dir_vec("legacy_basic",   3'b011, 8'd3,   8'd5,   8'd10,  8'h02, 8'h02, 1'b0);
        dir_vec("pos_ovf_200",    3'b000, 8'd100, 8'd100, 8'd0,   8'hC8, 8'h7F, 1'b1);
        dir_vec("neg_min_num1",   3'b001, 8'h80,  8'h00,  8'h00,  8'h80, 8'h7F, 1'b1);
        dir_vec("neg_min_all",    3'b111, 8'h80,  8'h80,  8'h80,  8'h80, 8'h7F, 1'b1);
        dir_vec("sum_min_all",    3'b000, 8'h80,  8'h80,  8'h80,  8'h80, 8'h80, 1'b1);
        dir_vec("max_boundary",   3'b000, 8'h7F,  8'h00,  8'h00,  8'h7F, 8'h7F, 1'b0);
        dir_vec("min_boundary",   3'b000, 8'h80,  8'h00,  8'h00,  8'h80, 8'h80, 1'b0);
        dir_vec("neg_ovf_m129",   3'b100, 8'h80,  8'h00,  8'h01,  8'h7F, 8'h80, 1'b1);
        dir_vec("pos_ovf_128",    3'b010, 8'h7F,  8'hFF,  8'h00,  8'h80, 8'h7F, 1'b1);
        dir_vec("zero_sum",       3'b110, 8'd50,  8'd20,  8'd30,  8'h00, 8'h00, 1'b0);
        dir_vec("legacy_neg",     3'b011, 8'd10,  8'd20,  8'd5,   8'hE7, 8'hE7, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [7:0] k;
        logic [7:0] exp_v;
        logic       acc;
        int         n_acc;
        k = 8'd1;
        n_acc = 0;
        drive(1'b1, 8'h00, 8'h00, k, 3'b000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            if (i >= 2) begin
                tests_run++;
                if (obs() !== {2'b11, 8'h01, 8'h01, 2'b00}) begin
                    tests_failed++;
                    $display("FAIL stall_hold_%0d: got %h, expected %h", i, obs(), {2'b11, 8'h01, 8'h01, 2'b00});
                end
            end
            acc = bw.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                k++;
            end
            drive(1'b1, 8'h00, 8'h00, k, 3'b000, 1'b0);
        end
        #1;
        tests_run++;
        if (n_acc != 2) begin
            tests_failed++;
            $display("FAIL stall_accept_count: got %0d, expected 2", n_acc);
        end
        tests_run++;
        if ({bw.in_ready, bs.in_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL stall_in_ready: got %b, expected 00", {bw.in_ready, bs.in_ready});
        end
        drive(1'b1, 8'h00, 8'h00, k, 3'b000, 1'b1);
        exp_v = 8'd1;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests_run++;
            if ({obs(), bw.in_ready, bs.in_ready} !== {2'b11, exp_v, exp_v, 2'b00, 2'b11}) begin
                tests_failed++;
                $display("FAIL drain_stream_%0d: got %h, expected %h", i, {obs(), bw.in_ready, bs.in_ready}, {2'b11, exp_v, exp_v, 2'b00, 2'b11});
            end
            exp_v++;
            acc = bw.in_ready;
            @(posedge clk); #1;
            if (acc) k++;
            drive(1'b1, 8'h00, 8'h00, k, 3'b000, 1'b1);
        end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (obs() !== {2'b11, exp_v, exp_v, 2'b00}) begin
                tests_failed++;
                $display("FAIL drain_tail_%0d: got %h, expected %h", i, obs(), {2'b11, exp_v, exp_v, 2'b00});
            end
            exp_v++;
            @(posedge clk); #1;
        end
        tests_run++;
        if ({bw.out_valid, bs.out_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL drain_empty: got %b, expected 00", {bw.out_valid, bs.out_valid});
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] q[$];
        logic [16:0] e;
        logic [7:0]  a, b, c;
        logic [2:0]  n;
        logic        ordy;
        int          sent, recv, cycles;
        sent = 0; recv = 0; cycles = 0;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); n = 3'($urandom);
        while (recv < 16 && cycles < 300) begin
            ordy = (cycles >= 100) || ($urandom_range(0, 3) != 0);
            drive(sent < 16, a, b, c, n, ordy);
            #1;
            if (bw.out_valid && bw.out_ready) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_unexpected: got %h, expected no output", obs());
                end else begin
                    e = q.pop_front();
                    if (obs() !== {2'b11, e[16:9], e[8:1], e[0], e[0]}) begin
                        tests_failed++;
                        $display("FAIL b2b_result_%0d: got %h, expected %h", recv, obs(), {2'b11, e[16:9], e[8:1], e[0], e[0]});
                    end
                end
                recv++;
            end
            if (bw.in_valid && bw.in_ready) begin
                q.push_back(model(a, b, c, n));
                sent++;
                a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); n = 3'($urandom);
            end
            @(posedge clk); #1;
            cycles++;
        end
        tests_run++;
        if (recv != 16 || q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_complete: got %0d results with %0d pending, expected 16 and 0", recv, q.size());
        end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1);
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 8'd1, 8'd2, 8'd3, 3'b000, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 8'd4, 8'd5, 8'd6, 3'b000, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
        #1;
        tests_run++;
        if ({obs(), bw.in_ready, bs.in_ready} !== {2'b11, 8'h06, 8'h06, 2'b00, 2'b00}) begin
            tests_failed++;
            $display("FAIL midflight_full: got %h, expected %h", {obs(), bw.in_ready, bs.in_ready}, {2'b11, 8'h06, 8'h06, 2'b00, 2'b00});
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({obs(), bw.in_ready, bs.in_ready} !== {20'h0, 2'b11}) begin
            tests_failed++;
            $display("FAIL midflight_reset: got %h, expected %h", {obs(), bw.in_ready, bs.in_ready}, {20'h0, 2'b11});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if ({bw.out_valid, bs.out_valid, bw.in_ready, bs.in_ready} !== 4'b0011) begin
                tests_failed++;
                $display("FAIL midflight_stale_%0d: got %b, expected 0011", i, {bw.out_valid, bs.out_valid, bw.in_ready, bs.in_ready});
            end
            @(posedge clk); #1;
        end
        drive(1'b1, 8'd7, 8'd8, 8'd9, 3'b000, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1);
        tests_run++;
        if ({bw.out_valid, bs.out_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL midflight_latency: got %b, expected 00", {bw.out_valid, bs.out_valid});
        end
        @(posedge clk); #1;
        tests_run++;
        if (obs() !== {2'b11, 8'h18, 8'h18, 2'b00}) begin
            tests_failed++;
            $display("FAIL midflight_new_result: got %h, expected %h", obs(), {2'b11, 8'h18, 8'h18, 2'b00});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
